// File: rtl/duck_round_controller_if.sv
// duck_round_controller_if: gun front end inputs and duck drawer / HUD outputs of the round controller
interface duck_round_controller_if;
  logic        frame_tick, start, trigger, duck_hit;
  logic        duck_rst, duck_en, duck_falling, round_done;
  logic [1:0]  ammo;
  logic [3:0]  ducks_left, hits;
  logic [13:0] score;
  logic [2:0]  state;
  modport master (
    output frame_tick, start, trigger, duck_hit,
    input  duck_rst, duck_en, duck_falling, round_done, ammo, ducks_left, hits, score, state
  );
  modport slave (
    input  frame_tick, start, trigger, duck_hit,
    output duck_rst, duck_en, duck_falling, round_done, ammo, ducks_left, hits, score, state
  );
endinterface

// File: rtl/duck_round_controller.sv
// duck_round_controller: sequences spawn/fly/fall/escape of each duck in a round and keeps ammo, hits and score
module duck_round_controller #(
  parameter int unsigned SHOTS_PER_DUCK  = 3,
  parameter int unsigned DUCKS_PER_ROUND = 10,
  parameter int unsigned SPAWN_FRAMES    = 30,
  parameter int unsigned FLY_FRAMES      = 600,
  parameter int unsigned FALL_FRAMES     = 60,
  parameter int unsigned SCORE_PER_HIT   = 10
) (
  input logic clk,
  input logic reset,
  duck_round_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SPAWN, FLY, FALL, ESCAPE, NEXT, DONE} state_t;
  state_t      st, st_n;
  logic [9:0]  cnt, cnt_n, lim;
  logic [1:0]  ammo_r, ammo_n;
  logic [3:0]  left_r, left_n, hits_r, hits_n;
  logic [13:0] score_r, score_n;
  logic [14:0] sum;
  logic        drst_r, drst_n, en_r, en_n, fall_r, fall_n, done_r, done_n;
  logic        timeout, shot;
  always_comb begin
    st_n    = st;
    ammo_n  = ammo_r;
    left_n  = left_r;
    hits_n  = hits_r;
    score_n = score_r;
    sum     = {1'b0, score_r} + 15'(SCORE_PER_HIT);
    lim     = st == SPAWN ? 10'(SPAWN_FRAMES - 1) : st == FLY ? 10'(FLY_FRAMES - 1) : 10'(FALL_FRAMES - 1);
    timeout = bus.frame_tick && cnt == lim;
    shot    = bus.trigger && ammo_r != 2'd0;
    case (st)
      IDLE, DONE: if (bus.start) begin
        st_n    = SPAWN;
        left_n  = 4'(DUCKS_PER_ROUND);
        hits_n  = '0;
        score_n = '0;
      end
      SPAWN: if (timeout) st_n = FLY;
      FLY: begin
        if (shot) ammo_n = ammo_r - 2'd1;
        // a hit beats both the last-miss escape and a coincident timeout
        if (shot && bus.duck_hit) begin
          st_n    = FALL;
          hits_n  = hits_r < 4'(DUCKS_PER_ROUND) ? hits_r + 4'd1 : hits_r;
          score_n = sum[14] ? 14'h3FFF : sum[13:0];
        end else if ((shot && ammo_r == 2'd1) || timeout) st_n = ESCAPE;
      end
      FALL, ESCAPE: if (timeout) st_n = NEXT;
      NEXT: begin
        left_n = left_r - 4'd1;
        st_n   = left_r == 4'd1 ? DONE : SPAWN;
      end
      default: st_n = IDLE;
    endcase
    drst_n = st_n == SPAWN && st != SPAWN;
    if (drst_n) ammo_n = 2'(SHOTS_PER_DUCK);
    cnt_n  = st_n != st ? '0 : cnt + 10'(bus.frame_tick);
    en_n   = st_n == FLY || st_n == FALL || st_n == ESCAPE;
    fall_n = st_n == FALL;
    done_n = st_n == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= IDLE;
      cnt     <= '0;
      ammo_r  <= '0;
      left_r  <= '0;
      hits_r  <= '0;
      score_r <= '0;
      drst_r  <= 1'b0;
      en_r    <= 1'b0;
      fall_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      ammo_r  <= ammo_n;
      left_r  <= left_n;
      hits_r  <= hits_n;
      score_r <= score_n;
      drst_r  <= drst_n;
      en_r    <= en_n;
      fall_r  <= fall_n;
      done_r  <= done_n;
    end
  end
  assign bus.state        = st;
  assign bus.ammo         = ammo_r;
  assign bus.ducks_left   = left_r;
  assign bus.hits         = hits_r;
  assign bus.score        = score_r;
  assign bus.duck_rst     = drst_r;
  assign bus.duck_en      = en_r;
  assign bus.duck_falling = fall_r;
  assign bus.round_done   = done_r;
endmodule

// File: tb/tb_duck_round_controller.sv
// tb_duck_round_controller: directed round scenarios with a queued scoreboard drained on each falling edge
module tb_duck_round_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  duck_round_controller_if bus ();
  duck_round_controller #(
    .SHOTS_PER_DUCK(3), .DUCKS_PER_ROUND(2), .SPAWN_FRAMES(2),
    .FLY_FRAMES(8), .FALL_FRAMES(3), .SCORE_PER_HIT(10)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {S_STATE, S_AMMO, S_HITS, S_SCORE, S_LEFT, S_EN, S_RST, S_FALL, S_DONE} sel_t;
  typedef struct {string nm; sel_t sel; int exp;} exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  function automatic logic [31:0] probe(input sel_t s);
    case (s)
      S_STATE: return 32'(bus.state);
      S_AMMO:  return 32'(bus.ammo);
      S_HITS:  return 32'(bus.hits);
      S_SCORE: return 32'(bus.score);
      S_LEFT:  return 32'(bus.ducks_left);
      S_EN:    return 32'(bus.duck_en);
      S_RST:   return 32'(bus.duck_rst);
      S_FALL:  return 32'(bus.duck_falling);
      default: return 32'(bus.round_done);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() != 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = probe(e.sel);
      compared++;
      if (act !== e.exp[31:0]) begin
        mismatched++;
        $display("FAIL %s: got %0d expected %0d at %0t", e.nm, act, e.exp, $time);
      end
    end
  end

  task automatic chk(input string nm, input sel_t s, input int v);
    q.push_back('{nm, s, v});
  endtask

  task automatic drive(input logic ft, input logic st, input logic tr, input logic hit);
    bus.frame_tick = ft; bus.start = st; bus.trigger = tr; bus.duck_hit = hit;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.trigger = 1'b0; bus.duck_hit = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.trigger = 1'b0; bus.duck_hit = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_state", S_STATE, 0); chk("rst_ammo", S_AMMO, 0); chk("rst_left", S_LEFT, 0);
    chk("rst_score", S_SCORE, 0); chk("rst_en", S_EN, 0); chk("rst_done", S_DONE, 0);
    // spawn of the first duck
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("spawn_state", S_STATE, 1); chk("spawn_rst", S_RST, 1); chk("spawn_ammo", S_AMMO, 3);
    chk("spawn_en", S_EN, 0); chk("spawn_left", S_LEFT, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_pulse_end", S_RST, 0); chk("trig_in_spawn_ammo", S_AMMO, 3);
    frames(1); chk("spawn_hold", S_STATE, 1);
    frames(1); chk("fly_state", S_STATE, 2); chk("fly_en", S_EN, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1); chk("hit_no_trig_state", S_STATE, 2); chk("hit_no_trig_hits", S_HITS, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0); chk("start_in_fly", S_STATE, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("hit_state", S_STATE, 3); chk("hit_ammo", S_AMMO, 2); chk("hit_hits", S_HITS, 1);
    chk("hit_score", S_SCORE, 10); chk("hit_falling", S_FALL, 1);
    frames(2); chk("fall_hold", S_STATE, 3);
    frames(1); chk("next_state", S_STATE, 5);
    drive(1'b0, 1'b0, 1'b0, 1'b0); chk("respawn_state", S_STATE, 1); chk("respawn_left", S_LEFT, 1);
    chk("respawn_rst", S_RST, 1); chk("respawn_ammo", S_AMMO, 3);
    // second duck: three misses then escape
    frames(2); chk("fly2_state", S_STATE, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0); chk("miss1_ammo", S_AMMO, 2); chk("miss1_state", S_STATE, 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0); chk("miss2_ammo", S_AMMO, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0); chk("miss3_ammo", S_AMMO, 0); chk("miss3_state", S_STATE, 4);
    chk("escape_falling", S_FALL, 0); chk("escape_en", S_EN, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1); chk("trig_escape_ammo", S_AMMO, 0); chk("trig_escape_hits", S_HITS, 1);
    frames(3); chk("esc_next", S_STATE, 5);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done1_state", S_STATE, 6); chk("done1_flag", S_DONE, 1); chk("done1_left", S_LEFT, 0);
    chk("done1_hits", S_HITS, 1); chk("done1_score", S_SCORE, 10); chk("done1_en", S_EN, 0);
    // timeout round
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart_hits", S_HITS, 0); chk("restart_score", S_SCORE, 0); chk("restart_left", S_LEFT, 2);
    frames(2);
    frames(7); chk("fly_7ticks", S_STATE, 2);
    frames(1); chk("timeout_state", S_STATE, 4); chk("timeout_ammo", S_AMMO, 3);
    frames(3); drive(1'b0, 1'b0, 1'b0, 1'b0); chk("to_respawn", S_STATE, 1);
    frames(2); frames(7);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk("hit_at_timeout_state", S_STATE, 3); chk("hit_at_timeout_hits", S_HITS, 1);
    chk("hit_at_timeout_ammo", S_AMMO, 2);
    frames(3); drive(1'b0, 1'b0, 1'b0, 1'b0); chk("done2_state", S_STATE, 6);
    // full round, both ducks hit
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    frames(2); drive(1'b0, 1'b0, 1'b1, 1'b1); frames(3); drive(1'b0, 1'b0, 1'b0, 1'b0);
    frames(2); drive(1'b0, 1'b0, 1'b1, 1'b1); chk("hit2_score", S_SCORE, 20);
    frames(3); drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_state", S_STATE, 6); chk("full_done", S_DONE, 1); chk("full_hits", S_HITS, 2);
    chk("full_score", S_SCORE, 20);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("new_hits", S_HITS, 0); chk("new_score", S_SCORE, 0); chk("new_left", S_LEFT, 2);
    chk("new_state", S_STATE, 1); chk("new_done", S_DONE, 0);
    // asynchronous reset in the middle of a fall
    frames(2); drive(1'b0, 1'b0, 1'b1, 1'b1); frames(1);
    chk("pre_reset_fall", S_STATE, 3);
    @(posedge clk); #2;
    reset = 1'b1; bus.trigger = 1'b1; bus.duck_hit = 1'b1; bus.start = 1'b1;
    #1;
    chk("areset_state", S_STATE, 0); chk("areset_hits", S_HITS, 0); chk("areset_score", S_SCORE, 0);
    chk("areset_en", S_EN, 0); chk("areset_fall", S_FALL, 0); chk("areset_ammo", S_AMMO, 0);
    chk("areset_left", S_LEFT, 0);
    repeat (2) @(posedge clk);
    #1 chk("hold_reset_state", S_STATE, 0); chk("hold_reset_ammo", S_AMMO, 0);
    reset = 1'b0; bus.trigger = 1'b0; bus.duck_hit = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1 chk("post_reset_state", S_STATE, 0);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
